// File: rtl/imem_refill_arbiter.sv
// imem_refill_arbiter
// Round-robin arbiter sharing one read-only burst memory port between
// NUM_REQ cache refill engines. One burst is outstanding at a time; the
// returning beats are steered to the requester that owns the burst.
module imem_refill_arbiter #(
    parameter  int NUM_REQ = 2,
    parameter  int BURST_W = 5,
    localparam int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*32-1:0]      req_addr,
    input  logic [NUM_REQ*BURST_W-1:0] req_len,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [NUM_REQ-1:0]         rd_valid,
    output logic [31:0]                rd_data,
    output logic                       mem_request,
    output logic [31:0]                mem_addr,
    output logic [BURST_W-1:0]         mem_len,
    input  logic                       mem_ack,
    input  logic                       mem_rd_valid,
    input  logic [31:0]                mem_rd_data,
    output logic                       busy,
    output logic [GW-1:0]              grant_id,
    output logic                       protocol_error
);

    localparam logic [GW-1:0] LAST_ID = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [GW-1:0]        r_rr_ptr;
    logic [GW-1:0]        r_grant_id;
    logic [31:0]          r_mem_addr;
    logic [BURST_W-1:0]   r_mem_len;
    logic [BURST_W-1:0]   r_beat_count;
    logic                 r_protocol_error;

    logic                 w_found;
    logic [GW-1:0]        w_winner;
    logic [GW-1:0]        w_rr_nxt;
    logic [31:0]          w_win_addr;
    logic [BURST_W-1:0]   w_win_len;
    logic                 w_ack_en;
    logic                 w_beat;
    logic                 w_last_beat;

    // First set request bit at or above ptr, wrapping; MSB of result = found.
    function automatic logic [GW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [GW-1:0]      ptr);
        logic [GW:0]   pick;
        logic [GW-1:0] idx;
        pick = '0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = GW'((int'(ptr) + i) % NUM_REQ);
            pick = valid[idx] ? {1'b1, idx} : pick;
        end
        return pick;
    endfunction

    // Pointer value just past the given requester, modulo NUM_REQ.
    function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] id);
        return (id == LAST_ID) ? '0 : id + GW'(1'b1);
    endfunction

    // Round-robin winner selection and post-grant pointer.
    always_comb begin
        {w_found, w_winner} = rr_pick(req_valid, r_rr_ptr);
        w_rr_nxt            = rr_next(w_winner);
    end

    // AND-OR mux of the winner's address and length.
    always_comb begin
        w_win_addr = '0;
        w_win_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_win_addr = w_win_addr |
                         ({32{w_winner == GW'(i)}} & req_addr[i*32 +: 32]);
            w_win_len  = w_win_len |
                         ({BURST_W{w_winner == GW'(i)}} & req_len[i*BURST_W +: BURST_W]);
        end
    end

    // Last-beat detect: compare before incrementing so len = all-ones cannot wrap.
    always_comb begin
        w_last_beat = (r_beat_count == r_mem_len);
    end

    // FSM next-state and per-state strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_en    = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    w_ack_en    = 1'b1;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DATA: begin
                w_beat = mem_rd_valid;
                if (mem_rd_valid && w_last_beat) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // One-hot steering of ack and return-beat strobes to the granted port.
    always_comb begin
        req_ack  = '0;
        rd_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ack[i]  = w_ack_en && (r_grant_id == GW'(i));
            rd_valid[i] = w_beat   && (r_grant_id == GW'(i));
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the arbitration winner and its burst parameters in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_mem_addr <= 32'h0000_0000;
            r_mem_len  <= '0;
        end else if ((r_state == ST_IDLE) && w_found) begin
            r_rr_ptr   <= w_rr_nxt;
            r_grant_id <= w_winner;
            r_mem_addr <= w_win_addr;
            r_mem_len  <= w_win_len;
        end
    end

    // Beat counter: cleared on memory accept, advanced on each non-final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_count <= '0;
        end else if (w_ack_en) begin
            r_beat_count <= '0;
        end else if (w_beat && !w_last_beat) begin
            r_beat_count <= r_beat_count + BURST_W'(1'b1);
        end
    end

    // Sticky flag for return beats that arrive with no burst outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_protocol_error <= 1'b0;
        end else if (mem_rd_valid && (r_state != ST_DATA)) begin
            r_protocol_error <= 1'b1;
        end
    end

    assign mem_request    = (r_state == ST_REQ);
    assign busy           = (r_state != ST_IDLE);
    assign mem_addr       = r_mem_addr;
    assign mem_len        = r_mem_len;
    assign grant_id       = r_grant_id;
    assign protocol_error = r_protocol_error;
    assign rd_data        = mem_rd_data;

endmodule

// File: tb/tb_imem_refill_arbiter.sv
// Directed bench for imem_refill_arbiter with a beat scoreboard.
module tb_imem_refill_arbiter;

    localparam int NUM_REQ = 2;
    localparam int BURST_W = 5;

    logic                       clk;
    logic                       rst_n;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*32-1:0]      req_addr;
    logic [NUM_REQ*BURST_W-1:0] req_len;
    logic [NUM_REQ-1:0]         req_ack;
    logic [NUM_REQ-1:0]         rd_valid;
    logic [31:0]                rd_data;
    logic                       mem_request;
    logic [31:0]                mem_addr;
    logic [BURST_W-1:0]         mem_len;
    logic                       mem_ack;
    logic                       mem_rd_valid;
    logic [31:0]                mem_rd_data;
    logic                       busy;
    logic [0:0]                 grant_id;
    logic                       protocol_error;

    typedef struct packed {
        logic [1:0]  onehot;
        logic [31:0] data;
    } beat_t;

    beat_t q_beats[$];
    int    checks = 0;
    int    errors = 0;

    imem_refill_arbiter #(.NUM_REQ(NUM_REQ), .BURST_W(BURST_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .req_ack        (req_ack),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .mem_request    (mem_request),
        .mem_addr       (mem_addr),
        .mem_len        (mem_len),
        .mem_ack        (mem_ack),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_data    (mem_rd_data),
        .busy           (busy),
        .grant_id       (grant_id),
        .protocol_error (protocol_error)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expected beat and compare it with the DUT outputs.
    task automatic check_beat();
        beat_t b;
        if (q_beats.size() == 0) begin
            chk("beat_unexpected", {62'd0, rd_valid}, 64'd0);
        end else begin
            b = q_beats.pop_front();
            chk("beat_port", {62'd0, rd_valid}, {62'd0, b.onehot});
            chk("beat_data", {32'd0, rd_data}, {32'd0, b.data});
        end
    endtask

    // Serve one burst from the memory side. Entered after the caller's
    // tick/drive; leaves at a negedge with the DUT expected back in IDLE.
    task automatic do_burst(input int port, input logic [31:0] addr,
                            input logic [4:0] len, input int ack_delay,
                            input bit gaps, input bit keep);
        int         n;
        int         gap;
        logic [1:0] oh;
        oh = 2'b01 << port;
        n  = 0;
        @(negedge clk);
        while (mem_request !== 1'b1 && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk("mem_request", {63'd0, mem_request}, 64'd1);
        if (mem_request !== 1'b1) return;
        chk("grant_id", {63'd0, grant_id}, port);
        chk("mem_addr", {32'd0, mem_addr}, {32'd0, addr});
        chk("mem_len",  {59'd0, mem_len},  {59'd0, len});
        for (int d = 0; d < ack_delay; d++) begin
            tick();
            @(negedge clk);
            chk("hold_request", {63'd0, mem_request}, 64'd1);
            chk("hold_addr", {32'd0, mem_addr}, {32'd0, addr});
            chk("hold_len",  {59'd0, mem_len},  {59'd0, len});
            chk("hold_no_ack", {62'd0, req_ack}, 64'd0);
        end
        tick();
        mem_ack = 1'b1;
        @(negedge clk);
        chk("req_ack", {62'd0, req_ack}, {62'd0, oh});
        tick();
        mem_ack = 1'b0;
        if (!keep) req_valid = '0;
        for (int i = 0; i <= int'(len); i++) begin
            gap = gaps ? (i % 4) : 0;
            for (int g = 0; g < gap; g++) begin
                mem_rd_valid = 1'b0;
                @(negedge clk);
                chk("gap_rd_valid", {62'd0, rd_valid}, 64'd0);
                chk("gap_busy", {63'd0, busy}, 64'd1);
                tick();
            end
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'hA5A5_0000 + i;
            q_beats.push_back({oh, mem_rd_data});
            @(negedge clk);
            check_beat();
            chk("req_ack_once", {62'd0, req_ack}, 64'd0);
            tick();
        end
        mem_rd_valid = 1'b0;
        @(negedge clk);
        chk("burst_done_busy", {63'd0, busy}, 64'd0);
        chk("burst_done_rd_valid", {62'd0, rd_valid}, 64'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = '0;
        req_addr     = '0;
        req_len      = '0;
        mem_ack      = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = 32'h0000_0000;

        // Reset state.
        tick();
        tick();
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mem_request", {63'd0, mem_request}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_mem_len", {59'd0, mem_len}, 64'd0);
        chk("rst_grant_id", {63'd0, grant_id}, 64'd0);
        chk("rst_protocol_error", {63'd0, protocol_error}, 64'd0);
        chk("rst_req_ack", {62'd0, req_ack}, 64'd0);
        chk("rst_rd_valid", {62'd0, rd_valid}, 64'd0);
        tick();
        rst_n = 1'b1;

        // Single requester, 8-beat burst, ack two cycles after request.
        tick();
        req_valid       = 2'b01;
        req_addr[31:0]  = 32'h8000_0100;
        req_len[4:0]    = 5'd7;
        do_burst(0, 32'h8000_0100, 5'd7, 2, 1'b0, 1'b0);

        // Contention: both continuously requesting; pointer now favours port 1.
        tick();
        req_valid       = 2'b11;
        req_addr[31:0]  = 32'h1000_0000;
        req_addr[63:32] = 32'h2000_0000;
        req_len[4:0]    = 5'd3;
        req_len[9:5]    = 5'd3;
        do_burst(1, 32'h2000_0000, 5'd3, 0, 1'b0, 1'b1);
        tick();
        do_burst(0, 32'h1000_0000, 5'd3, 1, 1'b0, 1'b1);
        tick();
        do_burst(1, 32'h2000_0000, 5'd3, 0, 1'b0, 1'b1);
        tick();
        do_burst(0, 32'h1000_0000, 5'd3, 0, 1'b0, 1'b0);

        // Boundary lengths: single beat, then a full 32-beat burst.
        tick();
        req_valid       = 2'b01;
        req_addr[31:0]  = 32'h3000_0000;
        req_len[4:0]    = 5'd0;
        do_burst(0, 32'h3000_0000, 5'd0, 0, 1'b0, 1'b0);
        tick();
        req_valid       = 2'b10;
        req_addr[63:32] = 32'h4000_0000;
        req_len[9:5]    = 5'd31;
        do_burst(1, 32'h4000_0000, 5'd31, 1, 1'b0, 1'b0);

        // Backpressure (10 cycles) and beat gaps of 0..3 cycles.
        tick();
        req_valid       = 2'b01;
        req_addr[31:0]  = 32'h5000_0040;
        req_len[4:0]    = 5'd7;
        do_burst(0, 32'h5000_0040, 5'd7, 10, 1'b1, 1'b0);
        chk("no_error_so_far", {63'd0, protocol_error}, 64'd0);

        // Reset in the middle of a burst, then a stray beat.
        tick();
        req_valid       = 2'b01;
        req_addr[31:0]  = 32'h6000_0000;
        req_len[4:0]    = 5'd7;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("mid_mem_request", {63'd0, mem_request}, 64'd1);
        tick();
        mem_ack = 1'b1;
        @(negedge clk);
        tick();
        mem_ack   = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 2; i++) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'hA5A5_0000 + i;
            q_beats.push_back({2'b01, mem_rd_data});
            @(negedge clk);
            check_beat();
            tick();
        end
        mem_rd_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        chk("async_rst_rd_valid", {62'd0, rd_valid}, 64'd0);
        chk("async_rst_mem_request", {63'd0, mem_request}, 64'd0);
        mem_rd_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stray_rd_valid", {62'd0, rd_valid}, 64'd0);
        chk("stray_busy", {63'd0, busy}, 64'd0);
        tick();
        mem_rd_valid = 1'b0;
        @(negedge clk);
        chk("stray_protocol_error", {63'd0, protocol_error}, 64'd1);
        chk("stray_still_idle", {63'd0, busy}, 64'd0);

        // Clean reset clears the sticky flag.
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_protocol_error", {63'd0, protocol_error}, 64'd0);
        chk("rst2_mem_addr", {32'd0, mem_addr}, 64'd0);
        tick();
        rst_n = 1'b1;

        // Unsolicited beat in IDLE, flag stays set across a normal burst.
        tick();
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'h1234_5678;
        @(negedge clk);
        chk("idle_beat_rd_valid", {62'd0, rd_valid}, 64'd0);
        tick();
        mem_rd_valid = 1'b0;
        @(negedge clk);
        chk("idle_beat_protocol_error", {63'd0, protocol_error}, 64'd1);
        tick();
        req_valid       = 2'b10;
        req_addr[63:32] = 32'h7000_0080;
        req_len[9:5]    = 5'd2;
        do_burst(1, 32'h7000_0080, 5'd2, 0, 1'b0, 1'b0);
        chk("sticky_protocol_error", {63'd0, protocol_error}, 64'd1);

        chk("scoreboard_empty", q_beats.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
